// File: rtl/flowled_pkg.sv
// Shared definitions for the LED flow engine: pattern mode encodings,
// shift direction and the per-mode seed pattern.
package flowled_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL = 2'd0,
    MODE_ROTR = 2'd1,
    MODE_PING = 2'd2,
    MODE_FILL = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Returned 32 bits wide; callers keep the low led_w bits.
  function automatic logic [31:0] seed_of(input mode_t mode, input int led_w);
    case (mode)
      MODE_ROTR: return 32'd1 << (led_w - 1);
      MODE_FILL: return 32'd0;
      default:   return 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/flowled_if.sv
// Configuration valid/ready port of the LED flow engine.
interface flowled_if #(
  parameter int CNT_W = 24
) ();
  logic             cfg_valid;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_mode, output cfg_period, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_mode, input cfg_period, output cfg_ready);
endinterface

// File: rtl/flowled_prescaler.sv
// Step prescaler: counts 0..period while run is high and flags the wrap edge.
module flowled_prescaler #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             step
);
  logic [CNT_W-1:0] count;

  assign step = run && (count == period);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (step) begin
      count <= '0;
    end else if (run) begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/flowled_engine.sv
// LED flow engine: four selectable patterns advanced by a programmable
// prescaler, with a valid/ready configuration port that defers while running.
module flowled_engine
  import flowled_pkg::*;
#(
  parameter int               LED_W   = 8,
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] CNT_DEF = CNT_W'(10_000_000)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             run,
  flowled_if.slave         cfg,
  output logic             step_pulse,
  output logic [LED_W-1:0] led_out
);
  mode_t            mode;
  dir_t             dir;
  logic [CNT_W-1:0] period;
  logic             pending;
  mode_t            pend_mode;
  logic [CNT_W-1:0] pend_period;

  logic             step;
  logic             xfer;
  logic             load_direct;
  logic             load_pend;
  logic             load_any;
  mode_t            ld_mode;
  logic [CNT_W-1:0] ld_period;
  logic [31:0]      seed_all;
  logic [LED_W-1:0] seed;
  logic [LED_W-1:0] nxt_led;
  dir_t             nxt_dir;

  assign xfer        = cfg.cfg_valid && cfg.cfg_ready;
  assign load_direct = xfer && !run;
  // A deferred request lands on the next step edge, or at once if run drops.
  assign load_pend   = pending && (step || !run);
  assign load_any    = load_direct || load_pend;
  assign ld_mode     = load_pend ? pend_mode : mode_t'(cfg.cfg_mode);
  assign ld_period   = load_pend ? pend_period : cfg.cfg_period;
  assign seed_all    = seed_of(ld_mode, LED_W);
  assign seed        = seed_all[LED_W-1:0];

  generate
    if (LED_W < 32) begin : g_seed_trim
      logic unused_seed_hi;
      assign unused_seed_hi = ^seed_all[31:LED_W];
    end
  endgenerate

  flowled_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .run    (run),
    .clear  (load_any),
    .period (period),
    .step   (step)
  );

  always_comb begin
    nxt_led = led_out;
    nxt_dir = dir;
    case (mode)
      MODE_ROTL: nxt_led = {led_out[LED_W-2:0], led_out[LED_W-1]};
      MODE_ROTR: nxt_led = {led_out[0], led_out[LED_W-1:1]};
      MODE_PING: begin
        // Bouncing off an end flips direction and moves back in the same step.
        if (dir == DIR_LEFT) begin
          if (led_out[LED_W-1]) begin
            nxt_dir = DIR_RIGHT;
            nxt_led = led_out >> 1;
          end else begin
            nxt_led = led_out << 1;
          end
        end else begin
          if (led_out[0]) begin
            nxt_dir = DIR_LEFT;
            nxt_led = led_out << 1;
          end else begin
            nxt_led = led_out >> 1;
          end
        end
      end
      default:   nxt_led = {led_out[LED_W-2:0], ~led_out[LED_W-1]};
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_out       <= LED_W'(1);
      mode          <= MODE_ROTL;
      period        <= CNT_DEF;
      dir           <= DIR_LEFT;
      pending       <= 1'b0;
      cfg.cfg_ready <= 1'b1;
      step_pulse    <= 1'b0;
    end else begin
      step_pulse <= step;
      if (load_any) begin
        mode          <= ld_mode;
        period        <= ld_period;
        led_out       <= seed;
        dir           <= DIR_LEFT;
        pending       <= 1'b0;
        cfg.cfg_ready <= 1'b1;
      end else begin
        if (xfer) begin
          pending       <= 1'b1;
          cfg.cfg_ready <= 1'b0;
        end
        if (step) begin
          led_out <= nxt_led;
          dir     <= nxt_dir;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (xfer && run) begin
      pend_mode   <= mode_t'(cfg.cfg_mode);
      pend_period <= cfg.cfg_period;
    end
  end
endmodule

// File: tb/tb_flowled_engine.sv
// Scoreboard bench for flowled_engine with LED_W=4, CNT_DEF=2.
module tb_flowled_engine;
  localparam int LED_W = 4;
  localparam int CNT_W = 8;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             run;
  logic             step_pulse;
  logic [LED_W-1:0] led_out;

  int checks   = 0;
  int failures = 0;
  logic [LED_W-1:0] exp_q[$];

  flowled_if #(.CNT_W(CNT_W)) cfg_bus ();

  flowled_engine #(.LED_W(LED_W), .CNT_W(CNT_W), .CNT_DEF(8'd2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .run        (run),
    .cfg        (cfg_bus),
    .step_pulse (step_pulse),
    .led_out    (led_out)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] m, input logic [CNT_W-1:0] p);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_mode   = m;
    cfg_bus.cfg_period = p;
  endtask

  // Waits for n step pulses; each must arrive exactly gap clocks after the previous sample.
  task automatic expect_steps(input string tag, input int n, input int gap);
    int cyc;
    logic [LED_W-1:0] e;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!step_pulse && cyc < 40);
      chk({tag, "_gap"}, cyc, gap);
      e = exp_q.pop_front();
      chk({tag, "_led"}, {28'd0, led_out}, {28'd0, e});
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    run = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_mode = 2'd0;
    cfg_bus.cfg_period = '0;
    tick();
    sys_rst = 1'b0;
    chk("rst_led", {28'd0, led_out}, 32'h1);
    chk("rst_pulse", {31'd0, step_pulse}, 32'h0);
    chk("rst_ready", {31'd0, cfg_bus.cfg_ready}, 32'h1);

    // Rotate-left at the reset period
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    run = 1'b1;
    expect_steps("rotl", 4, 3);

    // Ping-pong, one step per clock
    run = 1'b0;
    offer(2'd2, 8'd0);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    chk("ping_seed", {28'd0, led_out}, 32'h1);
    chk("ping_seed_pulse", {31'd0, step_pulse}, 32'h0);
    chk("ping_seed_ready", {31'd0, cfg_bus.cfg_ready}, 32'h1);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    run = 1'b1;
    expect_steps("ping", 7, 1);

    // Fill/drain Johnson sequence
    run = 1'b0;
    offer(2'd3, 8'd0);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    chk("fill_seed", {28'd0, led_out}, 32'h0);
    exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    run = 1'b1;
    expect_steps("fill", 8, 1);

    // Deferred configuration while running; a second offer must be ignored
    run = 1'b0;
    offer(2'd0, 8'd2);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    run = 1'b1;
    exp_q.push_back(4'b0010);
    expect_steps("s4pre", 1, 3);
    offer(2'd1, 8'd0);
    tick();
    chk("s4_capture_ready", {31'd0, cfg_bus.cfg_ready}, 32'h0);
    chk("s4_capture_led", {28'd0, led_out}, 32'h2);
    offer(2'd2, 8'd5);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    chk("s4_ignored_ready", {31'd0, cfg_bus.cfg_ready}, 32'h0);
    exp_q.push_back(4'b1000);
    expect_steps("s4load", 1, 1);
    chk("s4_ready_back", {31'd0, cfg_bus.cfg_ready}, 32'h1);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
    expect_steps("s4run", 2, 1);

    // Pause mid-period
    run = 1'b0;
    offer(2'd0, 8'd2);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_frozen", {27'd0, step_pulse, led_out}, 32'h01);
    end
    run = 1'b1;
    exp_q.push_back(4'b0010);
    expect_steps("resume", 1, 2);

    // Reset while ping-pong runs right with a request pending
    run = 1'b0;
    offer(2'd2, 8'd0);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    run = 1'b1;
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0100};
    expect_steps("s6ping", 4, 1);
    offer(2'd3, 8'd0);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    chk("capture_on_step_led", {28'd0, led_out}, 32'h2);
    chk("capture_on_step_ready", {31'd0, cfg_bus.cfg_ready}, 32'h0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("s6_led", {28'd0, led_out}, 32'h1);
    chk("s6_ready", {31'd0, cfg_bus.cfg_ready}, 32'h1);
    chk("s6_pulse", {31'd0, step_pulse}, 32'h0);
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    expect_steps("s6rotl", 2, 3);

    // Pending request applied when run falls
    offer(2'd3, 8'd0);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    chk("drop_capture_ready", {31'd0, cfg_bus.cfg_ready}, 32'h0);
    run = 1'b0;
    tick();
    chk("drop_led", {28'd0, led_out}, 32'h0);
    chk("drop_ready", {31'd0, cfg_bus.cfg_ready}, 32'h1);
    chk("drop_pulse", {31'd0, step_pulse}, 32'h0);
    run = 1'b1;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0011);
    expect_steps("drop_fill", 2, 1);

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
